// File: rtl/alu_exec_ctrl_pkg.sv
// rtl/alu_exec_ctrl_pkg.sv - opcodes, states, PSR layout and opcode-class decode
package alu_exec_ctrl_pkg;

   localparam int OP_W = 8;

   // Shared ALU opcode encodings
   localparam logic [OP_W-1:0] OP_NOP    = 8'h00;
   localparam logic [OP_W-1:0] OP_AND    = 8'h01;
   localparam logic [OP_W-1:0] OP_OR     = 8'h02;
   localparam logic [OP_W-1:0] OP_XOR    = 8'h03;
   localparam logic [OP_W-1:0] OP_ADDCU  = 8'h04;
   localparam logic [OP_W-1:0] OP_ADD    = 8'h05;
   localparam logic [OP_W-1:0] OP_ADDU   = 8'h06;
   localparam logic [OP_W-1:0] OP_ADDC   = 8'h07;
   localparam logic [OP_W-1:0] OP_SUB    = 8'h09;
   localparam logic [OP_W-1:0] OP_CMP    = 8'h0B;
   localparam logic [OP_W-1:0] OP_NOT    = 8'h0F;
   localparam logic [OP_W-1:0] OP_ADDCUI = 8'h40;
   localparam logic [OP_W-1:0] OP_ADDI   = 8'h50;
   localparam logic [OP_W-1:0] OP_ADDUI  = 8'h60;
   localparam logic [OP_W-1:0] OP_ADDCI  = 8'h70;
   localparam logic [OP_W-1:0] OP_LSHI   = 8'h80;
   localparam logic [OP_W-1:0] OP_LSH    = 8'h84;
   localparam logic [OP_W-1:0] OP_ALSH   = 8'h85;
   localparam logic [OP_W-1:0] OP_RSHI   = 8'h88;
   localparam logic [OP_W-1:0] OP_RSH    = 8'h8C;
   localparam logic [OP_W-1:0] OP_ARSH   = 8'h8D;
   localparam logic [OP_W-1:0] OP_SUBI   = 8'h90;
   localparam logic [OP_W-1:0] OP_CMPI   = 8'hB0;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   // PSR is {C, F, L, N, Z}
   localparam int PSR_C = 4;
   localparam int PSR_F = 3;
   localparam int PSR_L = 2;
   localparam int PSR_N = 1;
   localparam int PSR_Z = 0;

   localparam logic [4:0] MASK_NONE = 5'b00000;
   localparam logic [4:0] MASK_FZ   = 5'b01001;
   localparam logic [4:0] MASK_CZ   = 5'b10001;
   localparam logic [4:0] MASK_LNZ  = 5'b00111;
   localparam logic [4:0] MASK_Z    = 5'b00001;

   typedef struct packed {
      logic       writes_back;
      logic       uses_imm;
      logic       imm_signed;
      logic [4:0] psr_mask;
      logic       illegal;
   } op_info_t;

   // ADDCI is deliberately absent: it has no ALU meaning and decodes as illegal
   function automatic op_info_t decode_op(input logic [OP_W-1:0] op);
      op_info_t i;
      i = '0;
      case (op)
         OP_ADD, OP_SUB, OP_ADDC:   begin i.writes_back = 1'b1; i.psr_mask = MASK_FZ; end
         OP_ADDI, OP_SUBI:          begin i.writes_back = 1'b1; i.uses_imm = 1'b1;
                                          i.imm_signed = 1'b1; i.psr_mask = MASK_FZ; end
         OP_ADDU, OP_ADDCU:         begin i.writes_back = 1'b1; i.psr_mask = MASK_CZ; end
         OP_ADDUI, OP_ADDCUI:       begin i.writes_back = 1'b1; i.uses_imm = 1'b1;
                                          i.psr_mask = MASK_CZ; end
         OP_CMP:                    i.psr_mask = MASK_LNZ;
         OP_CMPI:                   begin i.uses_imm = 1'b1; i.imm_signed = 1'b1;
                                          i.psr_mask = MASK_LNZ; end
         OP_LSH, OP_RSH, OP_ALSH, OP_ARSH:
                                    begin i.writes_back = 1'b1; i.psr_mask = MASK_Z; end
         OP_LSHI, OP_RSHI:          begin i.writes_back = 1'b1; i.uses_imm = 1'b1;
                                          i.psr_mask = MASK_Z; end
         OP_AND, OP_OR, OP_XOR, OP_NOT:
                                    i.writes_back = 1'b1;
         OP_NOP:                    i = '0;
         default:                   i.illegal = 1'b1;
      endcase
      return i;
   endfunction

   function automatic logic writes_back(input logic [OP_W-1:0] op);
      return decode_op(op).writes_back;
   endfunction

   function automatic logic uses_imm(input logic [OP_W-1:0] op);
      return decode_op(op).uses_imm;
   endfunction

   function automatic logic imm_signed(input logic [OP_W-1:0] op);
      return decode_op(op).imm_signed;
   endfunction

   function automatic logic [4:0] psr_mask(input logic [OP_W-1:0] op);
      return decode_op(op).psr_mask;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_decode.sv
// rtl/alu_exec_ctrl_decode.sv - combinational opcode-class decoder
module alu_op_decode
   import alu_exec_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   output logic            writes_back,
   output logic            uses_imm,
   output logic            imm_signed,
   output logic [4:0]      psr_mask,
   output logic            illegal
);

   op_info_t info;

   // Map the opcode to its class attributes
   always_comb begin
      info        = decode_op(opcode);
      writes_back = info.writes_back;
      uses_imm    = info.uses_imm;
      imm_signed  = info.imm_signed;
      psr_mask    = info.psr_mask;
      illegal     = info.illegal;
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - four-state execute sequencer around the 16-bit ALU
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int RADDR_W = 4,
   parameter int IMM_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               issue_valid,
   output logic               issue_ready,
   input  logic [OP_W-1:0]    issue_opcode,
   input  logic [RADDR_W-1:0] issue_rdest,
   input  logic [RADDR_W-1:0] issue_rsrc,
   input  logic [IMM_W-1:0]   issue_imm,
   input  logic               flush,
   output logic [RADDR_W-1:0] rf_raddr_a,
   output logic [RADDR_W-1:0] rf_raddr_b,
   input  logic [DATA_W-1:0]  rf_rdata_a,
   input  logic [DATA_W-1:0]  rf_rdata_b,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic [OP_W-1:0]    alu_opcode,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   input  logic [DATA_W-1:0]  alu_c,
   input  logic               alu_carry,
   input  logic               alu_flag,
   input  logic               alu_low,
   input  logic               alu_negative,
   input  logic               alu_zero,
   output logic [4:0]         psr,
   output logic               done,
   output logic               illegal
);

   state_t               state;
   logic [OP_W-1:0]      opcode_q;
   logic [RADDR_W-1:0]   rdest_q;
   logic [RADDR_W-1:0]   rsrc_q;
   logic [IMM_W-1:0]     imm_q;

   logic                 dec_wb;
   logic                 dec_imm;
   logic                 dec_signed;
   logic [4:0]           dec_mask;
   logic                 dec_illegal;
   logic [DATA_W-1:0]    imm_ext;
   logic [DATA_W-1:0]    b_operand;
   logic [4:0]           alu_flags;

   alu_op_decode u_decode (
      .opcode      (opcode_q),
      .writes_back (dec_wb),
      .uses_imm    (dec_imm),
      .imm_signed  (dec_signed),
      .psr_mask    (dec_mask),
      .illegal     (dec_illegal)
   );

   // Operand B selection and writeback/readback wiring from the latched fields
   always_comb begin
      imm_ext    = dec_signed ? {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q}
                              : {{(DATA_W-IMM_W){1'b0}}, imm_q};
      b_operand  = dec_imm ? imm_ext : rf_rdata_b;
      alu_flags  = {alu_carry, alu_flag, alu_low, alu_negative, alu_zero};
      rf_raddr_a = rdest_q;
      rf_raddr_b = rsrc_q;
      rf_waddr   = rdest_q;
      rf_wdata   = alu_c;
      // Combinational so that a flush in WB can still cancel the write
      rf_we      = (state == S_WB) && dec_wb && !flush;
   end

   // Sequencer: IDLE -> READ -> EXEC -> WB, with flush short-circuiting to IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         psr         <= '0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_opcode  <= OP_NOP;
         issue_ready <= 1'b1;
         done        <= 1'b0;
         illegal     <= 1'b0;
         opcode_q    <= '0;
         rdest_q     <= '0;
         rsrc_q      <= '0;
         imm_q       <= '0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (issue_valid) begin
                  opcode_q    <= issue_opcode;
                  rdest_q     <= issue_rdest;
                  rsrc_q      <= issue_rsrc;
                  imm_q       <= issue_imm;
                  alu_opcode  <= issue_opcode;
                  issue_ready <= 1'b0;
                  state       <= S_READ;
               end
            end
            S_READ: begin
               if (flush) begin
                  state       <= S_IDLE;
                  issue_ready <= 1'b1;
                  alu_opcode  <= OP_NOP;
                  done        <= 1'b1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (flush) begin
                  state       <= S_IDLE;
                  issue_ready <= 1'b1;
                  alu_opcode  <= OP_NOP;
                  done        <= 1'b1;
               end else begin
                  alu_a   <= rf_rdata_a;
                  alu_b   <= b_operand;
                  done    <= 1'b1;
                  illegal <= dec_illegal;
                  state   <= S_WB;
               end
            end
            S_WB: begin
               if (!flush) begin
                  psr <= (psr & ~dec_mask) | (alu_flags & dec_mask);
               end
               state       <= S_IDLE;
               issue_ready <= 1'b1;
               alu_opcode  <= OP_NOP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
